// File: rtl/apb_gpio_slave.sv
// APB completer for a small GPIO register file: pin data/direction registers,
// synchronised pin inputs and a rising-edge level interrupt.
module apb_gpio_slave #(
    parameter int PADDR_SIZE  = 32,
    parameter int PDATA_SIZE  = 32,
    parameter int GPIO_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [GPIO_WIDTH-1:0]   gpio_i,
    output logic [GPIO_WIDTH-1:0]   gpio_o,
    output logic [GPIO_WIDTH-1:0]   gpio_oe,
    output logic                    irq
);
    localparam int NB = PDATA_SIZE / 8;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [GPIO_WIDTH-1:0]   data_out, dir, irq_en, irq_stat;
    logic [GPIO_WIDTH-1:0]   sync1, sync2, sync3;
    logic [GPIO_WIDTH-1:0]   wmask, wdata, rise, w1c;
    logic [PDATA_SIZE-1:0]   bmask, rdata;
    logic [5:0]              reg_idx;
    logic                    err, wr_en;
    logic                    unused_ok;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign bmask[8*k +: 8] = {8{PSTRB[k]}};
    end

    assign unused_ok = ^{PADDR, PWDATA, bmask};
    assign reg_idx   = PADDR[7:2];
    assign wmask     = bmask[GPIO_WIDTH-1:0];
    assign wdata     = PWDATA[GPIO_WIDTH-1:0];

    assign PREADY  = PSEL & PENABLE & (state == ACCESS) & (cnt == WS);
    assign err     = (reg_idx > 6'd4) | (PWRITE & (reg_idx == 6'd2));
    assign PSLVERR = PREADY & err;
    assign wr_en   = PREADY & PWRITE & ~err;
    assign PRDATA  = (PREADY & ~PWRITE & ~err) ? rdata : '0;

    // Input edges on pins currently driven as outputs are ignored.
    assign rise = sync2 & ~sync3 & ~dir;
    assign w1c  = (wr_en && reg_idx == 6'd4) ? (wdata & wmask) : '0;

    always_comb begin
        rdata = '0;
        case (reg_idx)
            6'd0:    rdata[GPIO_WIDTH-1:0] = data_out;
            6'd1:    rdata[GPIO_WIDTH-1:0] = dir;
            6'd2:    rdata[GPIO_WIDTH-1:0] = sync2;
            6'd3:    rdata[GPIO_WIDTH-1:0] = irq_en;
            6'd4:    rdata[GPIO_WIDTH-1:0] = irq_stat;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                // A dropped PSEL abandons the transfer without any update.
                if (!PSEL || PREADY) state_nxt = IDLE;
                else if (PENABLE)    cnt_nxt   = cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            dir      <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sync1    <= gpio_i;
            sync2    <= sync1;
            sync3    <= sync2;
            // A new edge beats a simultaneous clear of the same bit.
            irq_stat <= (irq_stat & ~w1c) | rise;
            irq      <= |(irq_stat & irq_en);
            if (wr_en) begin
                case (reg_idx)
                    6'd0:    data_out <= (data_out & ~wmask) | (wdata & wmask);
                    6'd1:    dir      <= (dir      & ~wmask) | (wdata & wmask);
                    6'd3:    irq_en   <= (irq_en   & ~wmask) | (wdata & wmask);
                    default: ;
                endcase
            end
        end
    end

    assign gpio_o  = data_out;
    assign gpio_oe = dir;
endmodule

// File: tb/tb_apb_gpio_slave.sv
// Random and directed APB traffic into two GPIO slaves (0 and 3 wait states)
// compared against a cycle-stepped register-file model.
module tb_apb_gpio_slave;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       psel = '0;
    logic             penable = 1'b0, pwrite = 1'b0;
    logic [31:0]      paddr = '0, pwdata = '0, gpio_i = '0;
    logic [3:0]       pstrb = '0;
    logic [1:0][31:0] prdata, gpio_o, gpio_oe;
    logic [1:0]       pready, pslverr, irq;

    int errs = 0, checks = 0;

    // model state, one slot per DUT
    logic [1:0][31:0] m_dout, m_dir, m_ien, m_stat;
    logic [1:0]       m_irq;
    logic [31:0]      h1, h2, h3;
    logic             c_vld = 1'b0;
    int               c_d = 0;
    logic [5:0]       c_idx;
    logic [31:0]      c_data, c_mask;
    logic [31:0]      rd;

    always #5 clk = ~clk;

    apb_gpio_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .gpio_i(gpio_i),
        .gpio_o(gpio_o[0]), .gpio_oe(gpio_oe[0]), .irq(irq[0]));

    apb_gpio_slave #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .gpio_i(gpio_i),
        .gpio_o(gpio_o[1]), .gpio_oe(gpio_oe[1]), .irq(irq[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [5:0] idx);
        case (idx)
            6'd0:    return m_dout[d];
            6'd1:    return m_dir[d];
            6'd2:    return h2;
            6'd3:    return m_ien[d];
            6'd4:    return m_stat[d];
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the reference: edge detect on the 2-clock-delayed
    // pin history, pending write commit, then the interrupt level.
    task automatic model_step();
        logic [31:0] rz, clr;
        if (!rst) begin
            m_dout = '0; m_dir = '0; m_ien = '0; m_stat = '0; m_irq = '0;
            h1 = '0; h2 = '0; h3 = '0;
            c_vld = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                rz = h2 & ~h3 & ~m_dir[d];
                m_irq[d] = |(m_stat[d] & m_ien[d]);
                clr = '0;
                if (c_vld && c_d == d) begin
                    case (c_idx)
                        6'd0: m_dout[d] = (m_dout[d] & ~c_mask) | (c_data & c_mask);
                        6'd1: m_dir[d]  = (m_dir[d]  & ~c_mask) | (c_data & c_mask);
                        6'd3: m_ien[d]  = (m_ien[d]  & ~c_mask) | (c_data & c_mask);
                        6'd4: clr = c_data & c_mask;
                        default: ;
                    endcase
                end
                m_stat[d] = (m_stat[d] & ~clr) | rz;
            end
            c_vld = 1'b0;
            h3 = h2; h2 = h1; h1 = gpio_i;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("gpio_o", gpio_o[d], m_dout[d]);
            chk("gpio_oe", gpio_oe[d], m_dir[d]);
            chk("irq", {31'b0, irq[d]}, {31'b0, m_irq[d]});
        end
    endtask

    // Leaves PSEL asserted after completion so the caller may chain a
    // back-to-back transfer or call idle().
    task automatic apb(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rdo);
        logic [5:0] idx;
        logic       e;
        logic [31:0] exp;
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        paddr = addr; pwrite = we; pwdata = data; pstrb = strb;
        idx = addr[7:2];
        e = (idx > 6'd4) || (we && idx == 6'd2);
        rdo = '0;
        tick();
        penable = 1'b1;
        for (int k = 0; k <= ws(d); k++) begin
            #1;
            if (k < ws(d)) begin
                chk("pready_wait", {31'b0, pready[d]}, 32'h0);
            end else begin
                chk("pready", {31'b0, pready[d]}, 32'h1);
                chk("pslverr", {31'b0, pslverr[d]}, {31'b0, e});
                exp = (!we && !e) ? model_read(d, idx) : 32'h0;
                chk("prdata", prdata[d], exp);
                rdo = prdata[d];
                c_vld = we && !e; c_d = d; c_idx = idx;
                c_data = data; c_mask = strb_mask(strb);
            end
            tick();
        end
    endtask

    task automatic idle();
        psel = '0; penable = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int r;
        gpio_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk("rst_pready", {31'b0, pready[d]}, 32'h0);
                chk("rst_pslverr", {31'b0, pslverr[d]}, 32'h0);
                chk("rst_prdata", prdata[d], 32'h0);
            end
        end
        rst = 1'b1;
        repeat (3) tick();
        apb(0, 1'b0, 32'h08, 0, 4'h0, rd); idle();
        chk("datain_after_rst", rd, 32'hFFFF_FFFF);
        apb(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
        apb(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd); idle();

        apb(0, 1'b1, 32'h00, 32'hA5A5_1234, 4'hF, rd); idle();
        chk("gpio_o_write", gpio_o[0], 32'hA5A5_1234);
        apb(0, 1'b0, 32'h00, 0, 4'h0, rd); idle();
        chk("read_back", rd, 32'hA5A5_1234);

        apb(1, 1'b1, 32'h04, 32'h0, 4'hF, rd);
        apb(1, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'h2, rd); idle();
        chk("dir_strobe", gpio_oe[1], 32'h0000_FF00);
        apb(1, 1'b1, 32'h04, 32'h0, 4'hF, rd); idle();

        apb(0, 1'b1, 32'h08, 32'h1, 4'hF, rd);
        apb(0, 1'b0, 32'h40, 0, 4'h0, rd);
        apb(0, 1'b0, 32'h00, 0, 4'h0, rd); idle();
        chk("b2b_read", rd, 32'hA5A5_1234);

        // interrupt latency and W1C
        gpio_i = 32'h0; repeat (4) tick();
        apb(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
        apb(0, 1'b1, 32'h0C, 32'h1, 4'hF, rd); idle();
        gpio_i[0] = 1'b1;
        repeat (3) tick();
        chk("irq_lat3", {31'b0, irq[0]}, 32'h0);
        tick();
        chk("irq_lat4", {31'b0, irq[0]}, 32'h1);
        apb(0, 1'b1, 32'h10, 32'h1, 4'hF, rd); idle();
        chk("irq_cleared", {31'b0, irq[0]}, 32'h0);
        gpio_i[1] = 1'b1; repeat (5) tick();
        chk("irq_masked", {31'b0, irq[0]}, 32'h0);
        apb(0, 1'b0, 32'h10, 0, 4'h0, rd); idle();
        chk("stat_masked", rd, 32'h2);

        // edge landing on the same edge as its W1C
        gpio_i[2] = 1'b1; tick();
        apb(0, 1'b1, 32'h10, 32'h4, 4'hF, rd); idle();
        apb(0, 1'b0, 32'h10, 0, 4'h0, rd); idle();
        chk("w1c_race", rd & 32'h4, 32'h4);

        // edge on an output pin
        apb(0, 1'b1, 32'h04, 32'h8, 4'hF, rd); idle();
        gpio_i[3] = 1'b1; repeat (5) tick();
        apb(0, 1'b0, 32'h10, 0, 4'h0, rd); idle();
        chk("out_pin_edge", rd & 32'h8, 32'h0);

        // reset during the access phase of a write
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        tick(); penable = 1'b1; tick();
        rst = 1'b0; tick();
        rst = 1'b1; psel = '0; penable = 1'b0; tick();
        apb(1, 1'b0, 32'h00, 0, 4'h0, rd); idle();
        chk("rst_abort", rd, 32'h0);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 6);
            a = $urandom;
            a[7:2] = (r <= 4) ? 6'(r) : 6'($urandom_range(5, 63));
            if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ (32'h1 << $urandom_range(0, 31));
            apb($urandom_range(0, 1), 1'($urandom), a, $urandom, 4'($urandom), rd);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
- APB completer that consumes the transactions carried on the APB interface and implements the GPIO register file.
- Drives GPIO pin outputs and output-enables.
- Samples GPIO inputs through a 2-flop synchroniser and raises a level interrupt on rising input edges.
- Sits directly downstream of the APB bus.

Parameters:
- PADDR_SIZE, 32: APB address width.
- PDATA_SIZE, 32: APB data width; must be a multiple of 8.
- GPIO_WIDTH, 32: number of GPIO pins; must be ≤ PDATA_SIZE.
- WAIT_STATES, 0: access-phase wait cycles inserted before PREADY; range 0..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PADDR  input  PADDR_SIZE  byte address.
- PWRITE  input  1  1 = write.
- PSTRB  input  PDATA_SIZE/8  write byte strobes.
- PWDATA  input  PDATA_SIZE  write data.
- PRDATA  output  PDATA_SIZE  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  transfer error, valid with PREADY.
- gpio_i  input  GPIO_WIDTH  asynchronous pin inputs.
- gpio_o  output  GPIO_WIDTH  pin output values (DATA_OUT).
- gpio_oe  output  GPIO_WIDTH  pin output enables (DIR).
- irq  output  1  registered interrupt.

Behaviour:
- Reset (rst=0 at posedge):
  - DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, synchroniser flops, edge flop and wait counter all clear to 0.
  - FSM goes to IDLE.
  - gpio_o=0, gpio_oe=0, irq=0, PREADY=0, PSLVERR=0, PRDATA=0.
  - Reset mid-transfer aborts the transfer with no register update.
- Address decode uses PADDR[7:0]; upper bits are ignored; PADDR[1:0] are ignored.
  - 0x00 DATA_OUT: RW.
  - 0x04 DIR: RW, 1 = output.
  - 0x08 DATA_IN: RO, synchronised gpio_i.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_STATUS: W1C.
  - 0x14..0xFF unmapped.
- FSM states: IDLE, ACCESS.
  - IDLE→ACCESS when PSEL=1 and PENABLE=0 (setup phase); wait counter cleared.
  - In ACCESS with PSEL&PENABLE: counter increments each cycle while below WAIT_STATES.
  - PREADY = PSEL & PENABLE & (state==ACCESS) & (cnt==WAIT_STATES), combinational from registered state.
  - WAIT_STATES=0 gives a zero-wait, 2-cycle transfer.
  - ACCESS→IDLE on the edge where PREADY=1.
  - PSEL dropping in ACCESS without PREADY: return to IDLE, no update.
- Errors:
  - PSLVERR = PREADY & (unmapped address OR (PWRITE & address==0x08)); otherwise 0.
  - An errored transfer changes no register.
- Writes commit on the posedge where PREADY=1, PWRITE=1 and PSLVERR=0.
  - Byte lane k updates only if PSTRB[k]=1.
  - Bits ≥ GPIO_WIDTH are discarded.
  - IRQ_STATUS write: each bit written 1 (with strobe) clears that bit.
- Reads:
  - PRDATA = selected register, zero-extended, when PREADY & !PWRITE & !PSLVERR; otherwise 0.
  - DATA_IN returns sync2 (gpio_i delayed 2 clocks).
- Synchroniser and edge detect:
  - sync1 <= gpio_i; sync2 <= sync1; sync3 <= sync2.
  - rise = sync2 & ~sync3 & ~DIR.
  - IRQ_STATUS |= rise every cycle, independent of IRQ_EN.
  - Same-cycle rise and W1C on the same bit: set wins, bit stays 1.
- Interrupt:
  - irq <= |(IRQ_STATUS & IRQ_EN), registered.
  - Sets 1 cycle after the status bit, i.e. 4 clocks after the gpio_i edge.
- Outputs: gpio_o = DATA_OUT and gpio_oe = DIR, direct register outputs; they update the cycle after write commit.
- Back-to-back transfers (setup immediately after PREADY) are supported with no idle cycle.

Test Plan:
- Reset: hold rst=0 for 3 clocks with gpio_i=0xFFFFFFFF → all outputs 0, irq=0; after release, read 0x08 returns 0xFFFFFFFF.
- Zero-wait write/read: write 0x00=0xA5A5_1234, PSTRB=0xF → gpio_o=0xA5A51234 the cycle after commit; read 0x00 returns 0xA5A51234, PSLVERR=0, PREADY high in the 2nd cycle.
- Byte strobes and wait states:
  - WAIT_STATES=3; DIR=0x0000_0000, then write 0x04=0xFFFF_FFFF with PSTRB=0x2 → DIR=0x0000_FF00.
  - PREADY is low for 3 access cycles and high on the 4th.
- Errors:
  - Write 0x08=0x1 → PSLVERR=1 with PREADY, DATA_IN unchanged.
  - Read 0x40 → PSLVERR=1, PRDATA=0.
  - A following read of 0x00 succeeds with no idle cycle.
- Interrupt:
  - IRQ_EN=0x1, DIR=0; drive gpio_i[0] 0→1 → IRQ_STATUS=0x1 after 3 clocks, irq=1 after 4.
  - Write 0x10=0x1 → IRQ_STATUS=0, irq=0 one cycle later.
  - An edge on gpio_i[1] with IRQ_EN[1]=0 sets the status bit but irq stays 0.
- Boundaries:
  - Rising edge arriving on the same cycle as a W1C of that bit → bit remains 1.
  - Edge on an output pin (DIR=1) → no status set.
  - rst=0 during the ACCESS of a write → register keeps its old value.
